// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot controller for the instruction memory. Receives a program image as a
//   byte stream, packs bytes into 32-bit little-endian words and writes them
//   into imem while holding the core in reset. When loading completes, the
//   core is released and the imem address port is handed to the fetch stage.
//
//   Image format: 4-byte word count N (LE), then N words of 4 bytes each (LE).
//   Word k is written to byte address {k, 2'b00}.
//
// Ports
//   i_clk        clock
//   i_rst_n      synchronous reset, active-low
//   i_rx_data    stream byte
//   i_rx_valid   stream byte valid
//   o_rx_ready   byte accepted when i_rx_valid && o_rx_ready
//   i_boot_start one-cycle pulse: restart loading from the header
//   i_cpu_addr   fetch address from the core
//   o_mem_addr   imem address (fetch address in RUN, load address otherwise)
//   o_mem_wdata  imem write data
//   o_mem_we     imem write enable, one cycle per word
//   o_cpu_rst_n  core reset, active-low; low outside RUN
//   o_busy       loading (HDR/DATA/WR)
//   o_done       core running (RUN)
//   o_err        bad header (ERR)
module imem_boot_loader #(
    parameter int ADDR_W        = 12,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic              i_boot_start,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int          IDX_W = ADDR_W - 2;
    localparam logic [32:0] DEPTH = 33'd1 << IDX_W;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WR,
        S_RUN,
        S_ERR
    } state_t;

    localparam state_t RESET_STATE = BOOT_ON_RESET ? S_HDR : S_RUN;

    state_t           r_state;
    logic [1:0]       r_byte_cnt;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_len;
    logic [31:0]      r_word;
    logic [31:0]      r_mem_wdata;

    logic             w_accept;
    logic [31:0]      w_full_len;
    logic [31:0]      w_full_word;
    logic             w_last_word;

    assign w_accept    = i_rx_valid && o_rx_ready;
    // Incoming byte completes the value in the top lane: first byte ends in [7:0].
    assign w_full_len  = {i_rx_data, r_len[31:8]};
    assign w_full_word = {i_rx_data, r_word[31:8]};
    assign w_last_word = ({{(32-IDX_W){1'b0}}, r_word_idx} == (r_len - 32'd1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= RESET_STATE;
            r_byte_cnt  <= '0;
            r_word_idx  <= '0;
            r_len       <= '0;
            r_word      <= '0;
            r_mem_wdata <= '0;
        end else if (i_boot_start) begin
            // A write in progress (WR) still completes: o_mem_we decodes the current state.
            r_state    <= S_HDR;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_len      <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_len      <= w_full_len;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_full_len == '0)
                                r_state <= S_RUN;
                            else if ({1'b0, w_full_len} > DEPTH)
                                r_state <= S_ERR;
                            else
                                r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= w_full_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_wdata <= w_full_word;
                            r_state     <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    r_word_idx <= r_word_idx + 1'b1;
                    r_state    <= w_last_word ? S_RUN : S_DATA;
                end
                S_RUN:   r_state <= S_RUN;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign o_rx_ready  = (r_state == S_HDR) || (r_state == S_DATA);
    assign o_mem_we    = (r_state == S_WR);
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_addr  = (r_state == S_RUN) ? i_cpu_addr : {r_word_idx, 2'b00};
    assign o_cpu_rst_n = (r_state == S_RUN);
    assign o_done      = (r_state == S_RUN);
    assign o_busy      = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WR);
    assign o_err       = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              boot_start;
    logic [ADDR_W-1:0] cpu_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    // Second instance: comes out of reset straight into RUN.
    logic              b_rx_ready;
    logic [ADDR_W-1:0] b_mem_addr;
    logic [31:0]       b_mem_wdata;
    logic              b_mem_we;
    logic              b_cpu_rst_n;
    logic              b_busy;
    logic              b_done;
    logic              b_err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .BOOT_ON_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready), .i_boot_start(boot_start), .i_cpu_addr(cpu_addr),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_cpu_rst_n(cpu_rst_n), .o_busy(busy), .o_done(done), .o_err(err)
    );

    imem_boot_loader #(.ADDR_W(ADDR_W), .BOOT_ON_RESET(1'b0)) dut_run (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(8'h00), .i_rx_valid(1'b0),
        .o_rx_ready(b_rx_ready), .i_boot_start(1'b0), .i_cpu_addr(12'h123),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_we(b_mem_we),
        .o_cpu_rst_n(b_cpu_rst_n), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard of expected writes, pushed as each word is driven.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                we_count  = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_count++;
            last_addr = mem_addr;
            check_eq("wr_rx_ready", {31'd0, rx_ready}, 32'd0);
            check_eq("sb_nonempty", {31'd0, (exp_addr.size() != 0)}, 32'd1);
            if (exp_addr.size() != 0) begin
                check_eq("wr_addr", {20'd0, mem_addr}, {20'd0, exp_addr.pop_front()});
                check_eq("wr_data", mem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int   n;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            r = rx_ready;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) check_eq("send_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        logic [31:0] t;
        t = w;
        for (int unsigned i = 0; i < 4; i++) begin
            send_byte(t[7:0], (gap_max > 0) ? int'($urandom_range(gap_max)) : 0);
            t = t >> 8;
        end
    endtask

    function automatic logic [31:0] pat(input int k, input logic [31:0] seed);
        return seed ^ (32'(k) * 32'h01030507);
    endfunction

    // Load an image of n words, data from pat(); ends with latency checks.
    task automatic load_image(input int n, input logic [31:0] seed, input int gap_max);
        send_word(32'(n), gap_max);
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(ADDR_W'(k * 4));
            exp_data.push_back(pat(k, seed));
            send_word(pat(k, seed), gap_max);
        end
        @(negedge clk);
        check_eq("lat_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        check_eq("lat_done", {31'd0, done}, 32'd1);
        check_eq("lat_busy", {31'd0, busy}, 32'd0);
        check_eq("lat_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    endtask

    task automatic pulse_boot();
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        boot_start = 1'b0;
        cpu_addr   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_ready", {31'd0, rx_ready}, 32'd1);
        check_eq("b_cpu_rst_n", {31'd0, b_cpu_rst_n}, 32'd1);
        check_eq("b_done", {31'd0, b_done}, 32'd1);
        check_eq("b_busy", {31'd0, b_busy}, 32'd0);
        check_eq("b_addr", {20'd0, b_mem_addr}, 32'h123);
        tick();

        // 1: two-word image from literal bytes
        exp_addr.push_back(12'h000); exp_data.push_back(32'h00000013);
        exp_addr.push_back(12'h004); exp_data.push_back(32'h00100093);
        send_word(32'd2, 0);
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 0);
        @(negedge clk);
        check_eq("t1_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        check_eq("t1_we_one_cycle", {31'd0, mem_we}, 32'd0);
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_we_count", 32'(we_count), 32'd2);

        // 6: address passthrough in RUN
        cpu_addr = 12'h0AC;
        #1;
        check_eq("t6_addr", {20'd0, mem_addr}, 32'h0AC);
        check_eq("t6_we", {31'd0, mem_we}, 32'd0);
        check_eq("t6_ready", {31'd0, rx_ready}, 32'd0);
        tick();

        // 2: empty image
        pulse_boot();
        base = we_count;
        send_word(32'd0, 0);
        @(negedge clk);
        check_eq("t2_done", {31'd0, done}, 32'd1);
        repeat (3) tick();
        check_eq("t2_no_we", 32'(we_count - base), 32'd0);

        // 3: oversize header -> ERR, then maximum-size image
        pulse_boot();
        send_word(32'd1025, 0);
        @(negedge clk);
        check_eq("t3_err", {31'd0, err}, 32'd1);
        check_eq("t3_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("t3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        tick();
        pulse_boot();
        @(negedge clk);
        check_eq("t3_err_clr", {31'd0, err}, 32'd0);
        check_eq("t3_busy", {31'd0, busy}, 32'd1);
        tick();
        base = we_count;
        load_image(1024, 32'hA5C3_0000, 0);
        check_eq("t3_we_count", 32'(we_count - base), 32'd1024);
        check_eq("t3_last_addr", {20'd0, last_addr}, 32'hFFC);

        // 4: same 8-word image gap-free then with random gaps
        for (int unsigned pass = 0; pass < 2; pass++) begin
            pulse_boot();
            base = we_count;
            load_image(8, 32'h5EED_1234, (pass == 0) ? 0 : 5);
            check_eq("t4_we_count", 32'(we_count - base), 32'd8);
        end

        // 5: restart mid-DATA discards the partial word
        pulse_boot();
        exp_addr.push_back(12'h000); exp_data.push_back(32'h11223344);
        send_word(32'd2, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h77, 0);
        pulse_boot();
        @(negedge clk);
        check_eq("t5_busy", {31'd0, busy}, 32'd1);
        check_eq("t5_addr", {20'd0, mem_addr}, 32'h000);
        tick();
        exp_addr.push_back(12'h000); exp_data.push_back(32'hDEADBEEF);
        send_word(32'd1, 0);
        send_word(32'hDEADBEEF, 0);
        repeat (2) tick();
        check_eq("t5_done", {31'd0, done}, 32'd1);

        // 5: reset mid-DATA
        pulse_boot();
        exp_addr.push_back(12'h000); exp_data.push_back(32'hCAFEF00D);
        send_word(32'd3, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check_eq("t5r_busy", {31'd0, busy}, 32'd1);
        check_eq("t5r_we", {31'd0, mem_we}, 32'd0);
        check_eq("t5r_addr", {20'd0, mem_addr}, 32'h000);
        check_eq("t5r_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        load_image(1, 32'h0BAD_CAFE, 0);

        repeat (2) tick();
        check_eq("sb_drain", 32'(exp_addr.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
